memory_responder: RTL and testbench

//  Responder (memory) side of the CPU memory handshake: readM/writeM/address/data/inputReady/ackOutput.
//  - Serves one word-wide request at a time from an internal WORD_SIZE-bit array.
//  - Inserts a programmable wait latency before answering.
//  - Sits opposite the datapath in the CPU testbench and system top.

---
 rtl/memory_responder.sv | 153 +++++++++++++++
 tb/tb_memory_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: memory side of the CPU read/write handshake with a programmable response latency.
// Optional feature macro ACCESS_COUNT_EN adds saturating read_count/write_count completion counters.
module memory_responder #(
    parameter int WORD_SIZE = 16,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 readM,
    input  logic                 writeM,
    input  logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 inputReady,
    output logic                 ackOutput
`ifdef ACCESS_COUNT_EN
    ,
    output logic [15:0]          read_count,
    output logic [15:0]          write_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAT_C = 4'(LATENCY);

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_count;
    logic [3:0]             w_count_next;
    logic                   r_is_write;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [WORD_SIZE-1:0]   r_wdata;
    logic [WORD_SIZE-1:0]   r_rdata;
    logic                   r_oe;
    logic [WORD_SIZE-1:0]   r_mem [MEM_DEPTH];
    logic                   w_new_req;
    logic                   w_req_line;
    logic                   w_mem_we;
    logic                   w_unused_addr;

    assign w_new_req     = readM | writeM;
    // Write wins when both lines are high, so the line that ends a transaction follows the latched op.
    assign w_req_line    = r_is_write ? writeM : readM;
    assign w_mem_we      = (r_state == S_RESP) && r_is_write && !reset;
    assign w_unused_addr = ^address[WORD_SIZE-1:ADDR_BITS];
    assign data          = (r_oe && !writeM) ? r_rdata : {WORD_SIZE{1'bz}};

    // Next-state and wait-counter logic.
    always_comb begin
        w_next       = r_state;
        w_count_next = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_new_req) begin
                    if (LAT_C == 4'd0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next       = S_BUSY;
                        w_count_next = LAT_C;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!w_req_line) begin
                    w_next       = S_IDLE;
                    w_count_next = 4'd0;
                end else if (r_count <= 4'd1) begin
                    w_next       = S_RESP;
                    w_count_next = 4'd0;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            S_RESP: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                if (!w_req_line) begin
                    w_next = S_IDLE;
                end else begin
                    w_next = S_DONE;
                end
            end
            default: begin
                w_next       = S_IDLE;
                w_count_next = 4'd0;
            end
        endcase
    end

    // State, request capture and registered response outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= 4'd0;
            r_is_write <= 1'b0;
            r_addr     <= {ADDR_BITS{1'b0}};
            r_wdata    <= {WORD_SIZE{1'b0}};
            r_rdata    <= {WORD_SIZE{1'b0}};
            r_oe       <= 1'b0;
            inputReady <= 1'b0;
            ackOutput  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_count <= w_count_next;
            if (r_state == S_IDLE && w_new_req) begin
                r_is_write <= writeM;
                r_addr     <= address[ADDR_BITS-1:0];
                r_wdata    <= data;
            end
            if (r_state == S_RESP && !r_is_write) begin
                r_rdata <= r_mem[r_addr];
            end
            inputReady <= (r_state == S_RESP) && !r_is_write;
            ackOutput  <= (r_state == S_RESP) && r_is_write;
            // Read data stays on the bus through DONE while the initiator still holds readM.
            r_oe       <= !r_is_write && ((r_state == S_RESP) || (r_state == S_DONE && readM));
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

`ifdef ACCESS_COUNT_EN
    // Saturating completion counters; aborted requests never reach RESP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_count  <= 16'd0;
            write_count <= 16'd0;
        end else if (r_state == S_RESP) begin
            if (r_is_write && write_count != 16'hFFFF) begin
                write_count <= write_count + 16'd1;
            end else if (!r_is_write && read_count != 16'hFFFF) begin
                read_count <= read_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Scoreboard bench for memory_responder: directed cases plus random traffic against a word-array model.
module tb_memory_responder;
    localparam int W   = 16;
    localparam int LAT = 2;

    typedef struct packed {
        logic        is_write;
        logic [15:0] val;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        readM, writeM;
    logic [W-1:0] address;
    logic [W-1:0] drv_data;
    logic        drv_en;
    wire  [W-1:0] data;
    logic        inputReady, ackOutput;

    logic        z_readM, z_writeM;
    logic [W-1:0] z_addr;
    logic [W-1:0] z_drv;
    logic        z_drv_en;
    wire  [W-1:0] z_data;
    logic        z_ir, z_ack;

`ifdef ACCESS_COUNT_EN
    logic [15:0] read_count, write_count, z_rc, z_wc;
    int          ref_rc = 0;
    int          ref_wc = 0;
`endif

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   pulses = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic [15:0] ref_mem [256];
    int   wlist[$];

    assign data   = drv_en   ? drv_data : {W{1'bz}};
    assign z_data = z_drv_en ? z_drv    : {W{1'bz}};

    memory_responder #(.WORD_SIZE(W), .MEM_DEPTH(256), .ADDR_BITS(8), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .readM(readM), .writeM(writeM), .address(address),
        .data(data), .inputReady(inputReady), .ackOutput(ackOutput)
`ifdef ACCESS_COUNT_EN
        , .read_count(read_count), .write_count(write_count)
`endif
    );

    memory_responder #(.WORD_SIZE(W), .MEM_DEPTH(256), .ADDR_BITS(8), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset), .readM(z_readM), .writeM(z_writeM), .address(z_addr),
        .data(z_data), .inputReady(z_ir), .ackOutput(z_ack)
`ifdef ACCESS_COUNT_EN
        , .read_count(z_rc), .write_count(z_wc)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (inputReady || ackOutput) begin
            pulses++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: inputReady=%0b ackOutput=%0b at cycle %0d, none expected",
                         inputReady, ackOutput, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if (ackOutput !== mon_e.is_write || inputReady !== !mon_e.is_write) begin
                    errors++;
                    $display("FAIL pulse_kind: ack=%0b ir=%0b, required ack=%0b ir=%0b",
                             ackOutput, inputReady, mon_e.is_write, !mon_e.is_write);
                end
                checks++;
                if (cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL pulse_time: got cycle %0d, required %0d", cyc, mon_e.at);
                end
                if (!mon_e.is_write) begin
                    checks++;
                    if (data !== mon_e.val) begin
                        errors++;
                        $display("FAIL read_data: got %h, required %h", data, mon_e.val);
                    end
                end
            end
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [15:0] addr,
                         input logic [15:0] wd, input int hold_extra);
        int n;
        int waited;
        logic [7:0] a;
        logic [15:0] ev;
        exp_t e;
        a = addr[7:0];
        readM = rd; writeM = wr; address = addr; drv_data = wd; drv_en = wr;
        @(posedge clk); #1;
        n = cyc;
        if (wr) begin
            ref_mem[a] = wd;
            wlist.push_back(int'(a));
            ev = wd;
`ifdef ACCESS_COUNT_EN
            ref_wc++;
`endif
        end else begin
            ev = ref_mem[a];
`ifdef ACCESS_COUNT_EN
            ref_rc++;
`endif
        end
        e.is_write = wr; e.val = ev; e.at = n + LAT + 1;
        sbq.push_back(e);
        if (wr) drv_data = 16'($urandom);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(inputReady || ackOutput) && waited < 20);
        checks++;
        if (!(inputReady || ackOutput)) begin
            errors++;
            $display("FAIL resp_timeout: no pulse within %0d cycles, required one", waited);
        end
        for (int i = 0; i < hold_extra; i++) begin
            @(negedge clk);
            checks++;
            if (data !== ev || inputReady !== 1'b0) begin
                errors++;
                $display("FAIL read_hold: data=%h ir=%0b, required data=%h ir=0", data, inputReady, ev);
            end
        end
        readM = 1'b0; writeM = 1'b0; drv_en = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int p0, zp, zc, n;
        logic [15:0] zd;
        reset = 1'b1; readM = 1'b0; writeM = 1'b0; address = '0; drv_data = '0; drv_en = 1'b0;
        z_readM = 1'b0; z_writeM = 1'b0; z_addr = '0; z_drv = '0; z_drv_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (inputReady !== 1'b0 || ackOutput !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ir=%0b ack=%0b, required 0/0", inputReady, ackOutput);
        end
        reset = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, 1'b1, 16'h0005, 16'h1234, 0);
        issue(1'b1, 1'b0, 16'h0005, 16'h0000, 2);
        issue(1'b0, 1'b1, 16'h0105, 16'hBEEF, 0);
        issue(1'b1, 1'b0, 16'h0005, 16'h0000, 1);
        issue(1'b1, 1'b1, 16'h0007, 16'h00A5, 0);
        issue(1'b1, 1'b0, 16'h0007, 16'h0000, 0);

        // Abort: request withdrawn one edge after being sampled.
        readM = 1'b1; address = 16'h0005;
        @(posedge clk); #1;
        readM = 1'b0;
        p0 = pulses;
        repeat (6) @(negedge clk);
        checks++;
        if (pulses != p0) begin
            errors++;
            $display("FAIL abort_no_pulse: %0d pulses, required 0", pulses - p0);
        end
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 16'h0005, 16'h0000, 0);

        // Reset while BUSY must drop the read silently.
        readM = 1'b1; address = 16'h0005;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        p0 = pulses;
        repeat (3) @(negedge clk);
        checks++;
        if (pulses != p0 || inputReady !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: pulses=%0d ir=%0b, required 0/0", pulses - p0, inputReady);
        end
        readM = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 16'h0005, 16'h0000, 0);

        for (int k = 0; k < 40; k++) begin
            int op;
            op = int'($urandom_range(0, 2));
            if (op == 1 && wlist.size() > 0) begin
                issue(1'b1, 1'b0, {8'($urandom), 8'(wlist[$urandom_range(0, wlist.size() - 1)])},
                      16'h0000, int'($urandom_range(0, 2)));
            end else begin
                issue(op == 2, 1'b1, 16'($urandom), 16'($urandom), 0);
            end
        end

        // LATENCY=0 instance: one pulse one edge after sampling, none while the read is held.
        z_writeM = 1'b1; z_addr = 16'h0003; z_drv = 16'h5A5A; z_drv_en = 1'b1;
        @(posedge clk); #1;
        n = cyc;
        @(posedge clk); #1;
        checks++;
        if (z_ack !== 1'b1 || cyc != n + 1) begin
            errors++;
            $display("FAIL lat0_write_ack: ack=%0b at cycle %0d, required 1 at %0d", z_ack, cyc, n + 1);
        end
        z_writeM = 1'b0; z_drv_en = 1'b0;
        @(posedge clk); #1;
        z_readM = 1'b1;
        zp = 0; zc = 0; zd = '0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (i == 0) n = cyc;
            if (z_ir) begin
                zp++; zc = cyc; zd = z_data;
            end
        end
        checks++;
        if (zp != 1 || zc != n + 1 || zd !== 16'h5A5A) begin
            errors++;
            $display("FAIL lat0_held_read: pulses=%0d cycle=%0d data=%h, required 1 at %0d data 5a5a",
                     zp, zc, zd, n + 1);
        end
        z_readM = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL outstanding: %0d expected responses never seen, required 0", sbq.size());
        end
`ifdef ACCESS_COUNT_EN
        checks++;
        if (int'(read_count) != ref_rc || int'(write_count) != ref_wc) begin
            errors++;
            $display("FAIL access_counts: rd=%0d wr=%0d, required rd=%0d wr=%0d",
                     read_count, write_count, ref_rc, ref_wc);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
